joystick_mapper_nch: RTL



---
 rtl/joystick_mapper_nch.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/joystick_mapper_nch.sv
// Multi-channel joystick front end: per-bit sync + debounce, per-channel autofire and
// Kempston / Fuller / Sinclair P1/P2 / Cursor emulation onto the CPU port and keyboard columns.
module joystick_mapper_nch #(
   parameter int         NUM_CH        = 2,
   parameter int         DEB_BITS      = 4,
   parameter logic [7:0] JOYCONF_BASE  = 8'h06,
   parameter logic [7:0] KEMPSTON_ADDR = 8'h1F,
   parameter logic [7:0] FULLER_ADDR   = 8'h7F
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [15:0]         a,
   input  logic                iorq_n,
   input  logic                rd_n,
   input  logic [7:0]          din,
   output logic [7:0]          dout,
   output logic                oe,
   input  logic [7:0]          zxuno_addr,
   input  logic                zxuno_regrd,
   input  logic                zxuno_regwr,
   input  logic [6*NUM_CH-1:0] joy_in,
   input  logic [4:0]          kbdcol_in,
   output logic [4:0]          kbdcol_out,
   input  logic                vertical_retrace_int_n
);
   localparam int NB = 6*NUM_CH;
   // Stable flips on the edge where the count would reach 2^DEB_BITS-1.
   localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'((2**DEB_BITS) - 2);

   genvar gi;

   logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NB-1:0] stable;
   logic [2:0]    vr_q, vr_d;   // {edge register, sync2, sync1}
   logic          tick;

   always_comb begin
      sync1_d = joy_in;
      sync2_d = sync1_q;
      vr_d    = {vr_q[1], vr_q[0], vertical_retrace_int_n};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         vr_q    <= 3'b111;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         vr_q    <= vr_d;
      end
   end

   assign tick = vr_q[1] & ~vr_q[2];

   for (gi = 0; gi < NB; gi++) begin : g_deb
      logic [DEB_BITS-1:0] cnt_q, cnt_d;
      logic                stable_q, stable_d, sample;

      assign sample = ~sync2_q[gi];

      always_comb begin
         cnt_d    = '0;
         stable_d = stable_q;
         if (sample != stable_q) begin
            if (cnt_q == DEB_LAST) stable_d = sample;
            else                   cnt_d    = cnt_q + DEB_BITS'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
         end
      end

      assign stable[gi] = stable_q;
   end

   logic [7:0]        cfg     [NUM_CH];
   logic [7:0]        kemp_b  [NUM_CH];
   logic [7:0]        full_b  [NUM_CH];
   logic [4:0]        p1_b    [NUM_CH];
   logic [4:0]        p2_b    [NUM_CH];
   logic [4:0]        cur12_b [NUM_CH];
   logic [4:0]        cur11_b [NUM_CH];
   logic [NUM_CH-1:0] rd_hit;

   for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [7:0] CH_ADDR = 8'(JOYCONF_BASE + gi);
      localparam logic [7:0] CFG_RST = (gi == 0) ? 8'h01 : ((gi == 1) ? 8'h02 : 8'h00);

      logic [7:0] cfg_q, cfg_d;
      logic [3:0] af_cnt_q, af_cnt_d, af_last;
      logic       phase_q, phase_d, wr_hit;
      logic       j_r, j_l, j_d, j_u, j_f1, j_f2, j_f;

      assign {j_f2, j_f1, j_u, j_d, j_l, j_r} = stable[6*gi +: 6];
      assign wr_hit     = zxuno_regwr && (zxuno_addr == CH_ADDR);
      assign rd_hit[gi] = zxuno_regrd && (zxuno_addr == CH_ADDR);
      assign af_last    = (cfg_q[7:4] == 4'd0) ? 4'd0 : cfg_q[7:4] - 4'd1;
      assign j_f        = j_f1 & (phase_q | ~cfg_q[3]);

      // A config write or a released F1 overrides any simultaneous frame tick.
      always_comb begin
         cfg_d    = wr_hit ? din : cfg_q;
         af_cnt_d = af_cnt_q;
         phase_d  = phase_q;
         if (wr_hit || !j_f1) begin
            af_cnt_d = 4'd0;
            phase_d  = 1'b1;
         end else if (tick) begin
            if (af_cnt_q == af_last) begin
               af_cnt_d = 4'd0;
               phase_d  = ~phase_q;
            end else begin
               af_cnt_d = af_cnt_q + 4'd1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cfg_q    <= CFG_RST;
            af_cnt_q <= 4'd0;
            phase_q  <= 1'b1;
         end else begin
            cfg_q    <= cfg_d;
            af_cnt_q <= af_cnt_d;
            phase_q  <= phase_d;
         end
      end

      assign cfg[gi]     = cfg_q;
      assign kemp_b[gi]  = {2'b00, j_f2, j_f, j_u, j_d, j_l, j_r};
      assign full_b[gi]  = {~j_f, ~j_f2, 2'b11, ~j_r, ~j_l, ~j_d, ~j_u};
      assign p1_b[gi]    = {~j_l, ~j_r, ~j_d, ~j_u, ~j_f};
      assign p2_b[gi]    = {~j_f, ~j_u, ~j_d, ~j_r, ~j_l};
      assign cur12_b[gi] = {~j_d, ~j_u, ~j_r, ~j_f2, ~j_f};
      assign cur11_b[gi] = {~j_l, 4'b1111};
   end

   logic       port_rd, sel12, sel11;
   logic [7:0] kemp_acc, full_acc, cfg_rd;
   logic [4:0] kbd_acc;
   logic       unused_a;

   assign port_rd  = !iorq_n && !rd_n;
   assign sel12    = port_rd && !a[0] && !a[12];
   assign sel11    = port_rd && !a[0] && !a[11];
   assign unused_a = ^{a[15:13], a[10:8]};

   always_comb begin
      kemp_acc = 8'h00;
      full_acc = 8'hFF;
      cfg_rd   = 8'h00;
      kbd_acc  = kbdcol_in;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_hit[c]) cfg_rd = cfg_rd | cfg[c];
         case (cfg[c][2:0])
            3'd1: kemp_acc = kemp_acc | kemp_b[c];
            3'd2: if (sel12) kbd_acc = kbd_acc & p1_b[c];
            3'd3: if (sel11) kbd_acc = kbd_acc & p2_b[c];
            3'd4: begin
               if (sel12) kbd_acc = kbd_acc & cur12_b[c];
               if (sel11) kbd_acc = kbd_acc & cur11_b[c];
            end
            3'd5: full_acc = full_acc & full_b[c];
            default: ;
         endcase
      end

      oe   = 1'b0;
      dout = 8'hFF;
      if (|rd_hit) begin
         oe   = 1'b1;
         dout = cfg_rd;
      end else if (port_rd && (a[7:0] == KEMPSTON_ADDR)) begin
         oe   = 1'b1;
         dout = kemp_acc;
      end else if (port_rd && (a[7:0] == FULLER_ADDR)) begin
         oe   = 1'b1;
         dout = full_acc;
      end
      kbdcol_out = kbd_acc;
   end
endmodule
